// File: rtl/apb_mem_slave.sv
// APB slave memory with byte strobes, programmable wait states and abort handling.
// Define APB_MEM_SLVERR_EN to report out-of-range accesses on PSLVERR.
module apb_mem_slave #(
  parameter int ADDWIDTH    = 8,
  parameter int DATAWIDTH   = 32,
  parameter int MEM_DEPTH   = 200,
  parameter int WAIT_CYCLES = 3
) (
  input  logic                   PCLK,
  input  logic                   PRESET,
  input  logic                   PSEL,
  input  logic                   PENABLE,
  input  logic                   PWRITE,
  input  logic [ADDWIDTH-1:0]    PADDR,
  input  logic [DATAWIDTH/8-1:0] PSTRB,
  input  logic [DATAWIDTH-1:0]   PWDATA,
  output logic                   PREADY,
  output logic [DATAWIDTH-1:0]   PRDATA,
  output logic                   PSLVERR
);

  // state | meaning
  // IDLE  | waiting for a setup cycle
  // WAIT  | access phase, counting down wait states
  // DONE  | PREADY high, completion edge pending

  localparam int NB     = DATAWIDTH / 8;
  localparam int AW_MEM = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDWIDTH:0] DEPTH_W = (ADDWIDTH+1)'(MEM_DEPTH);
  localparam logic [7:0] WAIT_LOAD = 8'(WAIT_CYCLES);
  localparam bit NO_WAIT = (WAIT_CYCLES == 0);
`ifdef APB_MEM_SLVERR_EN
  localparam bit SLVERR_EN = 1'b1;
`else
  localparam bit SLVERR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic enter_done, do_write;
  logic in_range;
  logic [AW_MEM-1:0] mem_idx;
  logic pready_q, pslverr_q;
  logic [DATAWIDTH-1:0] prdata_q;

  logic [DATAWIDTH-1:0] mem [MEM_DEPTH];

  assign in_range = ({1'b0, PADDR} < DEPTH_W);
  assign mem_idx  = PADDR[AW_MEM-1:0];

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    enter_done = 1'b0;
    do_write   = 1'b0;
    case (state)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          if (NO_WAIT) begin
            state_nxt  = DONE;
            enter_done = 1'b1;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = WAIT_LOAD;
          end
        end
      end
      WAIT: begin
        if (!PSEL) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (PENABLE) begin
          if (cnt == 8'd1) begin
            state_nxt  = DONE;
            enter_done = 1'b1;
            cnt_nxt    = '0;
          end else begin
            cnt_nxt = cnt - 8'd1;
          end
        end
      end
      DONE: begin
        if (!PSEL) begin
          state_nxt = IDLE;
        end else if (PENABLE) begin
          state_nxt = IDLE;
          do_write  = PWRITE && in_range;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Response registers are loaded only on entry to DONE and cleared on any exit.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      pready_q  <= 1'b0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
    end else if (enter_done) begin
      pready_q  <= 1'b1;
      prdata_q  <= (!PWRITE && in_range) ? mem[mem_idx] : '0;
      pslverr_q <= SLVERR_EN & ~in_range;
    end else if (state_nxt != DONE) begin
      pready_q  <= 1'b0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
    end
  end

  always_ff @(posedge PCLK) begin
    if (do_write) begin
      for (int i = 0; i < NB; i++) begin
        if (PSTRB[i]) mem[mem_idx][8*i +: 8] <= PWDATA[8*i +: 8];
      end
    end
  end

  assign PREADY  = pready_q;
  assign PRDATA  = pready_q ? prdata_q : '0;
  assign PSLVERR = pready_q & pslverr_q;

endmodule

// File: tb/tb_apb_mem_slave.sv
// Directed bench for apb_mem_slave: one instance with 3 wait states, one with none.
module tb_apb_mem_slave;

`ifdef APB_MEM_SLVERR_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic        psel3 = 1'b0, psel0 = 1'b0;
  logic        PENABLE = 1'b0, PWRITE = 1'b0;
  logic [7:0]  PADDR = '0;
  logic [3:0]  PSTRB = '0;
  logic [31:0] PWDATA = '0;
  logic        pready3, pslverr3, pready0, pslverr0;
  logic [31:0] prdata3, prdata0;

  int n_chk = 0;
  int n_bad = 0;

  always #5 PCLK = ~PCLK;

  apb_mem_slave #(.ADDWIDTH(8), .DATAWIDTH(32), .MEM_DEPTH(200), .WAIT_CYCLES(3)) dut3 (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel3), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PSTRB(PSTRB), .PWDATA(PWDATA),
    .PREADY(pready3), .PRDATA(prdata3), .PSLVERR(pslverr3));

  apb_mem_slave #(.ADDWIDTH(8), .DATAWIDTH(32), .MEM_DEPTH(200), .WAIT_CYCLES(0)) dut0 (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel0), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PSTRB(PSTRB), .PWDATA(PWDATA),
    .PREADY(pready0), .PRDATA(prdata0), .PSLVERR(pslverr0));

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One full transfer; leaves the bus selected so a following call is back-to-back.
  task automatic xfer(input bit fast, input logic wr, input logic [7:0] addr,
                      input logic [3:0] strb, input logic [31:0] wd,
                      output logic [31:0] rd, output logic err, output int cyc);
    PWRITE = wr; PADDR = addr; PSTRB = strb; PWDATA = wd;
    PENABLE = 1'b0; psel3 = !fast; psel0 = fast;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    cyc = 1;
    while (!(fast ? pready0 : pready3) && cyc < 40) begin
      @(posedge PCLK); #1;
      cyc++;
    end
    rd  = fast ? prdata0 : prdata3;
    err = fast ? pslverr0 : pslverr3;
    @(posedge PCLK); #1;
    check_val("pready_fall", 32'(fast ? pready0 : pready3), 32'd0);
  endtask

  task automatic bus_idle();
    psel3 = 1'b0; psel0 = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #1;
  endtask

  initial begin
    logic [31:0] rd;
    logic err;
    int cyc;
    bit seen;

    #12;
    check_val("rst_pready", 32'(pready3), 32'd0);
    check_val("rst_prdata", prdata3, 32'd0);
    check_val("rst_pslverr", 32'(pslverr3), 32'd0);
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    @(posedge PCLK); #1;
    check_val("post_rst_pready0", 32'(pready0), 32'd0);

    // write/read with 3 wait states
    xfer(0, 1, 8'd5, 4'hF, 32'hDEADBEEF, rd, err, cyc);
    check_val("wr5_cycles", 32'(cyc), 32'd4);
    check_val("wr5_err", 32'(err), 32'd0);
    xfer(0, 0, 8'd5, 4'h0, 32'h0, rd, err, cyc);
    check_val("rd5_cycles", 32'(cyc), 32'd4);
    check_val("rd5_data", rd, 32'hDEADBEEF);
    bus_idle();

    // byte strobes, then an all-zero strobe write
    xfer(0, 1, 8'd7, 4'hF, 32'h11223344, rd, err, cyc);
    xfer(0, 1, 8'd7, 4'b0101, 32'hAABBCCDD, rd, err, cyc);
    xfer(0, 0, 8'd7, 4'h0, 32'h0, rd, err, cyc);
    check_val("strb_data", rd, 32'h11BB33DD);
    xfer(0, 1, 8'd7, 4'h0, 32'hFFFFFFFF, rd, err, cyc);
    check_val("strb0_cycles", 32'(cyc), 32'd4);
    xfer(0, 0, 8'd7, 4'h0, 32'h0, rd, err, cyc);
    check_val("strb0_data", rd, 32'h11BB33DD);
    bus_idle();

    // zero wait states, back-to-back
    xfer(1, 1, 8'd0, 4'hF, 32'hCAFEF00D, rd, err, cyc);
    check_val("fast_wr_cycles", 32'(cyc), 32'd1);
    xfer(1, 0, 8'd0, 4'h0, 32'h0, rd, err, cyc);
    check_val("fast_rd_cycles", 32'(cyc), 32'd1);
    check_val("fast_rd_data", rd, 32'hCAFEF00D);
    bus_idle();

    // abort after one wait cycle
    xfer(0, 1, 8'd2, 4'hF, 32'h0BADC0DE, rd, err, cyc);
    PWRITE = 1'b1; PADDR = 8'd2; PSTRB = 4'hF; PWDATA = 32'h12345678;
    psel3 = 1'b1; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    psel3 = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge PCLK); #1;
      if (pready3) seen = 1;
    end
    check_val("abort_no_ready", 32'(seen), 32'd0);
    PENABLE = 1'b0;
    xfer(0, 0, 8'd2, 4'h0, 32'h0, rd, err, cyc);
    check_val("abort_data", rd, 32'h0BADC0DE);
    bus_idle();

    // reset mid-wait with the bus still driving the write afterwards
    xfer(0, 1, 8'd9, 4'hF, 32'h55AA55AA, rd, err, cyc);
    PWRITE = 1'b1; PADDR = 8'd9; PSTRB = 4'hF; PWDATA = 32'h99999999;
    psel3 = 1'b1; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #2;
    PRESET = 1'b1;
    #1;
    check_val("rstwait_pready", 32'(pready3), 32'd0);
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    repeat (6) @(posedge PCLK);
    #1;
    bus_idle();
    xfer(0, 0, 8'd9, 4'h0, 32'h0, rd, err, cyc);
    check_val("rstwait_data", rd, 32'h55AA55AA);
    bus_idle();

    // asynchronous reset while PREADY is high
    PWRITE = 1'b0; PADDR = 8'd5; psel3 = 1'b1; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    cyc = 1;
    while (!pready3 && cyc < 40) begin
      @(posedge PCLK); #1;
      cyc++;
    end
    check_val("rstdone_ready_seen", 32'(pready3), 32'd1);
    #2;
    PRESET = 1'b1;
    #1;
    check_val("rstdone_pready", 32'(pready3), 32'd0);
    check_val("rstdone_prdata", prdata3, 32'd0);
    psel3 = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    @(posedge PCLK); #1;

    // range boundaries
    xfer(0, 1, 8'd199, 4'hF, 32'h0F0F0F0F, rd, err, cyc);
    check_val("last_wr_err", 32'(err), 32'd0);
    xfer(0, 0, 8'd199, 4'h0, 32'h0, rd, err, cyc);
    check_val("last_rd_data", rd, 32'h0F0F0F0F);
    xfer(0, 1, 8'hFA, 4'hF, 32'h77777777, rd, err, cyc);
    check_val("oor_wr_cycles", 32'(cyc), 32'd4);
    check_val("oor_wr_err", 32'(err), 32'(EXP_ERR));
    xfer(0, 0, 8'hFA, 4'h0, 32'h0, rd, err, cyc);
    check_val("oor_rd_data", rd, 32'd0);
    check_val("oor_rd_err", 32'(err), 32'(EXP_ERR));
    xfer(0, 0, 8'd200, 4'h0, 32'h0, rd, err, cyc);
    check_val("oor200_data", rd, 32'd0);
    check_val("oor200_err", 32'(err), 32'(EXP_ERR));
    xfer(0, 0, 8'd5, 4'h0, 32'h0, rd, err, cyc);
    check_val("final_rd5", rd, 32'hDEADBEEF);
    check_val("final_err", 32'(err), 32'd0);
    bus_idle();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
